object_locator: RTL and testbench

//   Scans the incoming pixel stream, flags pixels matching a red target colour, and tracks
//   the per-frame bounding box of matches. At each frame boundary it publishes the box

---
 rtl/object_locator.sv | 170 +++++++++++++++++
 tb/tb_object_locator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/object_locator.sv
`default_nettype none
// ============================================================================
// Module      : object_locator
// Description : Flags red-target pixels in the stream, tracks the per-frame
//               bounding box of matches and publishes its centre at each SOF.
// Revision    : 1.0 - initial release
// ============================================================================
module object_locator #(
    parameter int                     COLOR_WIDTH = 10,
    parameter int                     DISP_WIDTH  = 11,
    parameter logic [COLOR_WIDTH-1:0] RED_MIN     = 10'd768,
    parameter logic [COLOR_WIDTH-1:0] GB_MAX      = 10'd256,
    parameter int                     MIN_PIXELS  = 16,
    parameter int                     CNT_WIDTH   = 20
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   enable,
    input  logic [COLOR_WIDTH-1:0] red,
    input  logic [COLOR_WIDTH-1:0] green,
    input  logic [COLOR_WIDTH-1:0] blue,
    input  logic [DISP_WIDTH-1:0]  x_pos,
    input  logic [DISP_WIDTH-1:0]  y_pos,
    output logic [DISP_WIDTH-1:0]  x_obj,
    output logic [DISP_WIDTH-1:0]  y_obj,
    output logic                   obj_found,
    output logic                   obj_valid
);

    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_PIXELS);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        CALC     = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_match;
    logic w_sof;
    logic w_init;
    logic w_snap;
    logic w_add;
    logic w_publish;

    logic [DISP_WIDTH-1:0] r_x_min, r_x_max, r_y_min, r_y_max;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [DISP_WIDTH-1:0] r_snap_x_min, r_snap_x_max, r_snap_y_min, r_snap_y_max;
    logic [CNT_WIDTH-1:0]  r_snap_count;

    logic [DISP_WIDTH:0]   w_x_sum, w_y_sum;

    assign w_match = (red >= RED_MIN) & (green <= GB_MAX) & (blue <= GB_MAX);
    assign w_sof   = enable & (x_pos == '0) & (y_pos == '0);

    // Sum at one extra bit so the centre of far-right/bottom boxes cannot wrap
    assign w_x_sum = {1'b0, r_snap_x_min} + {1'b0, r_snap_x_max};
    assign w_y_sum = {1'b0, r_snap_y_min} + {1'b0, r_snap_y_max};

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        w_snap      = 1'b0;
        w_add       = 1'b0;
        w_publish   = 1'b0;
        case (r_state)
            WAIT_SOF: begin
                if (w_sof) begin
                    w_init      = 1'b1;
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM, CALC: begin
                // CALC publishes the previous snapshot while pixels keep accumulating
                w_publish = (r_state == CALC);
                if (w_sof) begin
                    w_snap      = 1'b1;
                    w_init      = 1'b1;
                    w_state_nxt = CALC;
                end else begin
                    w_add       = enable & w_match;
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = WAIT_SOF;
            end
        endcase
    end

    // Bounding-box accumulators; the SOF pixel always seeds the new frame
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_x_min <= '1;
            r_x_max <= '0;
            r_y_min <= '1;
            r_y_max <= '0;
            r_count <= '0;
        end else if (w_init) begin
            if (w_match) begin
                r_x_min <= x_pos;
                r_x_max <= x_pos;
                r_y_min <= y_pos;
                r_y_max <= y_pos;
                r_count <= CNT_WIDTH'(1);
            end else begin
                r_x_min <= '1;
                r_x_max <= '0;
                r_y_min <= '1;
                r_y_max <= '0;
                r_count <= '0;
            end
        end else if (w_add) begin
            if (x_pos < r_x_min) r_x_min <= x_pos;
            if (x_pos > r_x_max) r_x_max <= x_pos;
            if (y_pos < r_y_min) r_y_min <= y_pos;
            if (y_pos > r_y_max) r_y_max <= y_pos;
            if (r_count != {CNT_WIDTH{1'b1}}) r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_snap_x_min <= '1;
            r_snap_x_max <= '0;
            r_snap_y_min <= '1;
            r_snap_y_max <= '0;
            r_snap_count <= '0;
        end else if (w_snap) begin
            r_snap_x_min <= r_x_min;
            r_snap_x_max <= r_x_max;
            r_snap_y_min <= r_y_min;
            r_snap_y_max <= r_y_max;
            r_snap_count <= r_count;
        end
    end

    // Position holds across frames where the object was not found
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            x_obj     <= '0;
            y_obj     <= '0;
            obj_found <= 1'b0;
            obj_valid <= 1'b0;
        end else begin
            obj_valid <= w_publish;
            if (w_publish) begin
                if (r_snap_count >= MIN_CNT) begin
                    x_obj     <= w_x_sum[DISP_WIDTH:1];
                    y_obj     <= w_y_sum[DISP_WIDTH:1];
                    obj_found <= 1'b1;
                end else begin
                    obj_found <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_object_locator.sv
`default_nettype none
// ============================================================================
// Module      : tb_object_locator
// Description : Frame-table and hand-sequence bench with result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_object_locator;

    localparam int CW = 10;
    localparam int DW = 11;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] red = '0, green = '0, blue = '0;
    logic [DW-1:0] x_pos = '0, y_pos = '0;
    logic [DW-1:0] x_obj, y_obj;
    logic          obj_found, obj_valid;

    // Narrow counter so saturation is reachable within small frames
    object_locator #(.CNT_WIDTH(5)) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .enable    (enable),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .x_obj     (x_obj),
        .y_obj     (y_obj),
        .obj_found (obj_found),
        .obj_valid (obj_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic found;
        int   x;
        int   y;
        int   due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        int   w, h, x0, x1, y0, y1;
        bit   half;
        logic found;
        int   ex, ey;
    } frame_t;
    frame_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (obj_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("latency", cyc, mon_e.due);
                chk("obj_found", {31'd0, obj_found}, {31'd0, mon_e.found});
                chk("x_obj", {21'd0, x_obj}, mon_e.x);
                chk("y_obj", {21'd0, y_obj}, mon_e.y);
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("missing_valid", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
    end

    task automatic drive(input bit en, input int x, input int y, input bit m);
        int sel;
        @(posedge clk);
        #1;
        sel    = $urandom_range(0, 5);
        enable = en;
        x_pos  = DW'(x);
        y_pos  = DW'(y);
        if (m) begin
            if (sel % 2 == 0) begin
                red = CW'(768);  green = CW'(256); blue = CW'(256);
            end else begin
                red = CW'(1023); green = CW'(0);   blue = CW'(0);
            end
        end else begin
            case (sel % 3)
                0:       begin red = CW'(767);  green = CW'(0);   blue = CW'(0);   end
                1:       begin red = CW'(1023); green = CW'(257); blue = CW'(0);   end
                default: begin red = CW'(1023); green = CW'(0);   blue = CW'(257); end
            endcase
        end
    endtask

    task automatic expect_at(input logic f, input int x, input int y);
        exp_t e;
        e.found = f;
        e.x     = x;
        e.y     = y;
        e.due   = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic pix(input int x, input int y, input bit m, input int n);
        for (int k = 0; k < n; k++) drive(1'b1, x, y, m);
    endtask

    task automatic sof(input bit m, input bit push, input logic f, input int x, input int y);
        drive(1'b1, 0, 0, m);
        if (push) expect_at(f, x, y);
    endtask

    task automatic run_frame(input frame_t fr, input bit push, input frame_t pf);
        bit m;
        for (int yy = 0; yy < fr.h; yy++) begin
            for (int xx = 0; xx < fr.w; xx++) begin
                // Disabled cycles carry matching colour at random coordinates
                if (fr.half && $urandom_range(0, 1) == 1)
                    drive(1'b0, $urandom_range(0, 63), $urandom_range(0, 47), 1'b1);
                m = (xx >= fr.x0) && (xx <= fr.x1) && (yy >= fr.y0) && (yy <= fr.y1);
                drive(1'b1, xx, yy, m);
                if (xx == 0 && yy == 0 && push) expect_at(pf.found, pf.ex, pf.ey);
            end
        end
    endtask

    initial begin
        tbl[0] = '{64, 48, 10, 19, 20, 29, 1'b0, 1'b1, 14, 24};
        tbl[1] = '{64, 48, 10, 19, 20, 29, 1'b1, 1'b1, 14, 24};
        tbl[2] = '{64, 48,  5, 19,  7,  7, 1'b0, 1'b0, 14, 24};
        tbl[3] = '{64, 48,  1,  0,  1,  0, 1'b0, 1'b0, 14, 24};
        tbl[4] = '{64, 48, 30, 40,  2,  3, 1'b0, 1'b1, 35,  2};
        tbl[5] = '{64, 48,  0, 63,  0, 47, 1'b0, 1'b1, 31, 23};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_x_obj", {21'd0, x_obj}, 32'd0);
        chk("reset_y_obj", {21'd0, y_obj}, 32'd0);
        chk("reset_found", {31'd0, obj_found}, 32'd0);
        chk("reset_valid", {31'd0, obj_valid}, 32'd0);
        aresetn = 1'b1;

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i], i > 0, (i > 0) ? tbl[i-1] : tbl[0]);

        // Repeated single pixel at the far corner; next SOF pixel matches
        sof(1'b0, 1'b1, tbl[5].found, tbl[5].ex, tbl[5].ey);
        pix(63, 47, 1'b1, 16);
        pix(30, 30, 1'b0, 4);
        sof(1'b1, 1'b1, 1'b1, 63, 47);
        pix(2, 2, 1'b1, 15);

        // Extreme coordinates exercise the widened centre sum
        sof(1'b0, 1'b1, 1'b1, 1, 1);
        pix(2047, 2047, 1'b1, 8);
        pix(2046, 2046, 1'b1, 8);

        // Back-to-back SOFs: second arrives during CALC
        sof(1'b0, 1'b1, 1'b1, 2046, 2046);
        pix(4, 6, 1'b1, 16);
        sof(1'b0, 1'b1, 1'b1, 4, 6);
        sof(1'b1, 1'b1, 1'b0, 4, 6);
        pix(8, 8, 1'b1, 15);
        sof(1'b0, 1'b1, 1'b1, 4, 4);
        pix(9, 9, 1'b1, 10);

        // Asynchronous reset mid-frame
        @(posedge clk);
        #2;
        aresetn = 1'b0;
        enable  = 1'b0;
        #1;
        chk("async_x_obj", {21'd0, x_obj}, 32'd0);
        chk("async_y_obj", {21'd0, y_obj}, 32'd0);
        chk("async_found", {31'd0, obj_found}, 32'd0);
        chk("async_valid", {31'd0, obj_valid}, 32'd0);
        chk("sb_empty_before_reset", sb.size(), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        pix(9, 9, 1'b1, 20);
        sof(1'b0, 1'b0, 1'b0, 0, 0);
        pix(20, 30, 1'b1, 16);
        sof(1'b0, 1'b1, 1'b1, 20, 30);
        pix(5, 5, 1'b0, 3);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
